// File: rtl/counter_checker.sv
// counter_checker
//   Consumer-side checker for a counter stream. Seeds on any sampled value,
//   confirms LOCK_COUNT consecutive consistent samples before declaring lock,
//   then flags every deviation with a one-cycle error pulse and a saturating
//   error count. The offending sample re-seeds the prediction.
//
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset (overrides en and err_clr)
//   en        : sample qualifier for in
//   in        : observed count value
//   err_clr   : synchronous clear of err_count (wins over an increment)
//   locked    : high while locked onto the sequence
//   error     : one-cycle pulse per mismatch seen while locked
//   err_count : saturating mismatch count
//   expected  : predicted value of the next sample
module counter_checker #(
   parameter int DATA_WIDTH = 8,
   parameter int COUNT_FROM = 0,
   parameter int COUNT_TO   = 10,
   parameter int STEP       = 1,
   parameter int LOCK_COUNT = 4,
   parameter int ERR_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] in,
   input  logic                  err_clr,
   output logic                  locked,
   output logic                  error,
   output logic [ERR_WIDTH-1:0]  err_count,
   output logic [DATA_WIDTH-1:0] expected
);

   localparam int RUN_W = $clog2(LOCK_COUNT + 1);

   // One extra bit so v + STEP never truncates before the wrap compare.
   localparam logic [DATA_WIDTH:0]   STEP_W = (DATA_WIDTH+1)'(STEP);
   localparam logic [DATA_WIDTH:0]   TO_W   = (DATA_WIDTH+1)'(COUNT_TO);
   localparam logic [DATA_WIDTH-1:0] FROM_W = DATA_WIDTH'(COUNT_FROM);
   localparam logic [RUN_W-1:0]      LOCK_W = RUN_W'(LOCK_COUNT);

   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] exp_q, exp_d;
   logic [RUN_W-1:0]      run_q, run_d;
   logic [ERR_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  err_q, err_d;
   logic                  err_inc;
   logic [DATA_WIDTH-1:0] in_next;

   function automatic logic [DATA_WIDTH-1:0] nxt(input logic [DATA_WIDTH-1:0] v);
      logic [DATA_WIDTH:0] s;
      s = {1'b0, v} + STEP_W;
      if (s > TO_W) return FROM_W;
      else          return s[DATA_WIDTH-1:0];
   endfunction

   assign in_next = nxt(in);

   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      run_d   = run_q;
      err_d   = 1'b0;
      err_inc = 1'b0;
      if (en) begin
         // Every sampled value becomes the basis of the next prediction,
         // whether it matched or is being used as a fresh seed.
         exp_d = in_next;
         unique case (state_q)
            HUNT: begin
               run_d   = RUN_W'(1);
               state_d = VERIFY;
            end
            VERIFY: begin
               if (in == exp_q) begin
                  run_d = run_q + RUN_W'(1);
                  if (run_q + RUN_W'(1) == LOCK_W) state_d = LOCKED;
               end else begin
                  run_d = RUN_W'(1);
               end
            end
            LOCKED: begin
               if (in != exp_q) begin
                  err_d   = 1'b1;
                  err_inc = 1'b1;
                  run_d   = RUN_W'(1);
                  state_d = VERIFY;
               end
            end
            default: state_d = HUNT;
         endcase
      end

      cnt_d = cnt_q;
      if (err_clr)                      cnt_d = '0;
      else if (err_inc && cnt_q != '1)  cnt_d = cnt_q + ERR_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= HUNT;
         exp_q   <= FROM_W;
         run_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         exp_q   <= exp_d;
         run_q   <= run_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign locked    = (state_q == LOCKED);
   assign error     = err_q;
   assign err_count = cnt_q;
   assign expected  = exp_q;

endmodule

// File: doc/counter_checker.md
# counter_checker

Sequence checker for the output of the `counter` primitive. It samples a count stream on `clk` while `en` is high and predicts each next value from the same `COUNT_FROM`/`COUNT_TO`/`STEP` parameters. It locks onto a valid sequence, then flags and counts any deviation. It sits at the consumer end of a counter link, in benches or in fabric, for example after a clock-domain or serial hop, to prove the count arrived intact.

## Interface
- `DATA_WIDTH`, 8: width of the checked count.
- `COUNT_FROM`, 0: first value after wrap.
- `COUNT_TO`, 10: upper bound of the sequence.
- `STEP`, 1: increment per sample; must be > 0. Legal range is `COUNT_FROM <= COUNT_TO < 2**DATA_WIDTH`.
- `LOCK_COUNT`, 4: consecutive consistent samples required to lock; must be >= 2.
- `ERR_WIDTH`, 16: width of the error counter.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: sample qualifier. `in` is checked only on edges where `en`=1.
- `in` in DATA_WIDTH: observed count value.
- `err_clr` in 1: synchronous clear of `err_count`.
- `locked` out 1: high while in state LOCKED.
- `error` out 1: one-cycle pulse per mismatch detected while locked.
- `err_count` out ERR_WIDTH: number of mismatches, saturating.
- `expected` out DATA_WIDTH: predicted value of the next sample.

## Operation
- next(v) = `COUNT_FROM` if v + `STEP` > `COUNT_TO`, else v + `STEP`. The sum is computed in DATA_WIDTH+1 bits so it never truncates.
- States are HUNT, VERIFY and LOCKED. Internal `run` counter is wide enough for `LOCK_COUNT`.
- HUNT, on `en`: `expected` <= next(`in`), `run` <= 1, go to VERIFY. Any value is accepted as a seed.
- VERIFY, on `en` with `in`==`expected`: `expected` <= next(`in`), `run` <= `run`+1. Go to LOCKED when `run`+1 == `LOCK_COUNT`.
- VERIFY, on `en` with a mismatch: reseed with `expected` <= next(`in`), `run` <= 1, stay in VERIFY. No error is raised.
- LOCKED, on `en` with a match: `expected` <= next(`in`).
- LOCKED, on `en` with a mismatch: `error` <= 1, `err_count` increments, reseed `expected` <= next(`in`), `run` <= 1, go to VERIFY.
- `en`=0: state, `expected`, `run` and `err_count` hold, and `in` is ignored. `error` <= 0 on every edge without a locked mismatch.
- `err_count` saturates at 2**ERR_WIDTH−1.
- `err_clr` sets `err_count` to 0. It wins over a simultaneous increment. `error` still pulses in that case.
- Reset values: state HUNT, `locked`=0, `error`=0, `err_count`=0, `expected`=`COUNT_FROM`, `run`=0. `rst` overrides `en` and `err_clr`.

## Timing
- All outputs are registered with no combinational path from inputs.
- `error`, `err_count` and `expected` update on the edge that samples the offending or predicted `in`. They are visible one cycle after `in` is presented.
- `locked` rises on the edge sampling the `LOCK_COUNT`-th consecutive consistent sample.
- `locked` falls on the same edge that raises `error`.
- `error` is high for exactly one cycle per mismatch. Back-to-back mismatches in LOCKED are not possible, because the first mismatch drops the block to VERIFY.
- Minimum relock after a mismatch is `LOCK_COUNT`−1 further matching samples, since the offending sample acts as the seed.

## Test plan
- Defaults: after reset, drive `en`=1 and `in`=0,1,2,3 → `locked`=1 after the 4th edge, `error` never asserted, `expected`=4.
- Wrap: while locked, drive 9,10,0,1 → no error, `expected`=0 after 10. With `STEP`=3, sequence 0,3,6,9,0 locks with no error (9+3 > 10 wraps).
- Mismatch: while locked with `expected`=5, drive 7 → `error`=1 for one cycle, `err_count`=1, `locked`=0, `expected`=8. Then drive 8,9,10 → `locked`=1 after 10.
- Gaps: while locked, hold `en`=0 for 10 cycles with random `in`, then resume the correct value → no error, `expected` unchanged across the gap.
- Saturation/clear: with `ERR_WIDTH`=2, cause 5 locked mismatches (relocking between each) → `err_count` stays at 3. Then assert `err_clr` on the edge of another mismatch → `err_count`=0 and `error`=1.
- Reset mid-run: while locked with `err_count`=2, pulse `rst` for one cycle with `en`=1 → the next cycle shows all reset values. The sample taken during `rst` is ignored, and the following sample seeds HUNT.
